fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, instruction width.
REQ-002 SHALL have parameter PC_BITS, default 5, word-addressed PC width.
REQ-003 SHALL have parameter BTB_IDX_BITS, default 3, BTB index width (2^BTB_IDX_BITS entries); SHALL be less than PC_BITS.
REQ-004 SHALL have parameter RESET_PC, default 0, PC value after reset.
REQ-005 SHALL have ports, in this order:
 clk  in  1  clock
 rst  in  1  synchronous, active-high reset
 stall_F  in  1  hold the PC
 EX_taken  in  1  redirect request from EX (mispredict or taken branch not predicted)
 EX_redirect_pc  in  PC_BITS  correct next PC
 EX_bp_update  in  1  branch resolved in EX this cycle
 EX_bp_pc  in  PC_BITS  PC of the resolved branch
 EX_bp_target  in  PC_BITS  resolved target
 EX_bp_outcome  in  1  1 = branch taken
 imem_addr  out  PC_BITS  instruction memory word address
 imem_rdata  in  XLEN  instruction word, combinational read of imem_addr
 F_pc  out  PC_BITS  PC of the instruction being fetched
 F_inst  out  XLEN  fetched instruction
 F_BP_taken  out  1  prediction for F_pc

Function
REQ-006 SHALL hold the PC in a PC_BITS register; imem_addr and F_pc SHALL equal it; F_inst SHALL equal imem_rdata with zero-cycle latency.
REQ-007 SHALL compute the next PC with this priority: rst -> RESET_PC; EX_taken -> EX_redirect_pc; stall_F -> hold; predicted taken -> BTB target; otherwise PC+1.
REQ-008 PC+1 SHALL wrap modulo 2^PC_BITS (all-ones -> 0).
REQ-009 The BTB SHALL use index = PC[BTB_IDX_BITS-1:0] and tag = the remaining upper PC bits; each entry SHALL hold a valid bit, tag, target, and 2-bit saturating counter.
REQ-010 F_BP_taken SHALL be 1 iff the entry is valid, its tag matches, and counter[1]=1; it SHALL be combinational from the current PC.
REQ-011 F_BP_taken SHALL be forced to 0 in any cycle where EX_taken=1, because that fetch is being squashed.
REQ-012 On EX_bp_update with a tag hit, the counter SHALL increment (saturating at 3) if taken and decrement (saturating at 0) if not; if taken, the target SHALL be overwritten.
REQ-013 On EX_bp_update with a miss (invalid or tag mismatch) and outcome taken, the unit SHALL allocate the entry: valid=1, tag and target written, counter=2.
REQ-014 On a miss with outcome not-taken, the BTB SHALL be unchanged.
REQ-015 BTB updates SHALL take effect at the clock edge; a lookup in the same cycle SHALL see the old contents (no bypass).
REQ-016 BTB updates SHALL proceed regardless of stall_F and EX_taken.
REQ-017 If stall_F=1 and EX_taken=1 together, the redirect SHALL win.

Reset
REQ-018 On a clock edge with rst=1: PC=RESET_PC, all BTB valid bits=0, all counters=1; any EX_bp_update that cycle SHALL be ignored.
REQ-019 After reset, F_pc=RESET_PC and F_BP_taken=0 until a BTB allocation hits.
REQ-020 Reset asserted mid-stall or mid-redirect SHALL override both.

Configuration
REQ-021 Macro FETCH_BP_EN: when defined, the BTB and predictor SHALL be built as above.
REQ-022 When FETCH_BP_EN is undefined, no BTB storage SHALL exist, F_BP_taken SHALL be tied to 0, EX_bp_* inputs SHALL be ignored, and the next PC SHALL be PC+1 unless a redirect, stall or reset applies.

Verification
REQ-023 Reset then 6 free-running cycles, imem[i]=i -> F_pc 0,1,2,3,4,5; F_inst equals F_pc; F_BP_taken=0 throughout.
REQ-024 PC=31 with no stall -> next F_pc=0 (wrap).
REQ-025 EX_bp_update pc=4, target=12, taken -> later fetch at PC 4 gives F_BP_taken=1, next F_pc=12; two not-taken updates at pc=4 -> F_BP_taken=0 at PC 4, next F_pc=5.
REQ-026 stall_F=1 for 3 cycles at PC 7 -> F_pc stays 7; then EX_taken=1 with EX_redirect_pc=20 while stall_F=1 -> next F_pc=20, F_BP_taken=0 in the redirect cycle.
REQ-027 Aliasing: allocate pc=4 (taken, target 12), then fetch pc=12 (same index, different tag) -> F_BP_taken=0; taken update at pc=12 with target 2 replaces the entry -> pc=4 now misses.
REQ-028 Build without FETCH_BP_EN and repeat REQ-025 -> F_BP_taken=0, sequential PCs; rst asserted mid-run -> F_pc=0 next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, next-PC selection and an optional direct-mapped BTB with 2-bit counters.
// Define FETCH_BP_EN to build the BTB/predictor; otherwise fetch is purely sequential.
module fetch_unit #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned PC_BITS      = 5,
  parameter int unsigned BTB_IDX_BITS = 3,
  parameter logic [PC_BITS-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_F,
  input  logic               EX_taken,
  input  logic [PC_BITS-1:0] EX_redirect_pc,
  input  logic               EX_bp_update,
  input  logic [PC_BITS-1:0] EX_bp_pc,
  input  logic [PC_BITS-1:0] EX_bp_target,
  input  logic               EX_bp_outcome,
  output logic [PC_BITS-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic [PC_BITS-1:0] F_pc,
  output logic [XLEN-1:0]    F_inst,
  output logic               F_BP_taken
);

  logic [PC_BITS-1:0] r_pc;
  logic [PC_BITS-1:0] w_pc_next;
  logic [PC_BITS-1:0] w_pc_plus1;
  logic               w_pred_taken;
  logic [PC_BITS-1:0] w_pred_target;

`ifdef FETCH_BP_EN
  localparam int TagBits = PC_BITS - BTB_IDX_BITS;
  localparam int Entries = 1 << BTB_IDX_BITS;

  logic [Entries-1:0] r_valid;
  logic [TagBits-1:0] r_tag    [Entries];
  logic [PC_BITS-1:0] r_target [Entries];
  logic [1:0]         r_ctr    [Entries];

  logic [BTB_IDX_BITS-1:0] w_lkp_idx;
  logic [TagBits-1:0]      w_lkp_tag;
  logic [BTB_IDX_BITS-1:0] w_upd_idx;
  logic [TagBits-1:0]      w_upd_tag;
  logic                    w_upd_hit;
  logic [1:0]              w_upd_ctr;

  assign w_lkp_idx = r_pc[BTB_IDX_BITS-1:0];
  assign w_lkp_tag = r_pc[PC_BITS-1:BTB_IDX_BITS];
  assign w_upd_idx = EX_bp_pc[BTB_IDX_BITS-1:0];
  assign w_upd_tag = EX_bp_pc[PC_BITS-1:BTB_IDX_BITS];

  // Lookup reads registered state only, so a same-cycle update is never bypassed.
  assign w_pred_taken  = r_valid[w_lkp_idx] && (r_tag[w_lkp_idx] == w_lkp_tag) &&
                         r_ctr[w_lkp_idx][1];
  assign w_pred_target = r_target[w_lkp_idx];

  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  always_comb begin
    w_upd_ctr = r_ctr[w_upd_idx];
    if (EX_bp_outcome) begin
      if (r_ctr[w_upd_idx] != 2'd3) w_upd_ctr = r_ctr[w_upd_idx] + 2'd1;
    end else begin
      if (r_ctr[w_upd_idx] != 2'd0) w_upd_ctr = r_ctr[w_upd_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < Entries; i++) r_ctr[i] <= 2'd1;
    end else if (EX_bp_update) begin
      if (w_upd_hit) begin
        r_ctr[w_upd_idx] <= w_upd_ctr;
        if (EX_bp_outcome) r_target[w_upd_idx] <= EX_bp_target;
      end else if (EX_bp_outcome) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= EX_bp_target;
        r_ctr[w_upd_idx]    <= 2'd2;
      end
    end
  end
`else
  logic w_unused_bp;
  assign w_unused_bp   = ^{EX_bp_update, EX_bp_pc, EX_bp_target, EX_bp_outcome};
  assign w_pred_taken  = 1'b0;
  assign w_pred_target = '0;
`endif

  assign w_pc_plus1 = r_pc + 1'b1;

  always_comb begin
    w_pc_next = w_pc_plus1;
    if (rst) begin
      w_pc_next = RESET_PC;
    end else if (EX_taken) begin
      w_pc_next = EX_redirect_pc;
    end else if (stall_F) begin
      w_pc_next = r_pc;
    end else if (w_pred_taken) begin
      w_pc_next = w_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    r_pc <= w_pc_next;
  end

  assign imem_addr = r_pc;
  assign F_pc      = r_pc;
  assign F_inst    = imem_rdata;
  // A redirecting cycle squashes this fetch, so its prediction is meaningless.
  assign F_BP_taken = w_pred_taken & ~EX_taken;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random stimulus against a
// behavioural model; follows FETCH_BP_EN to decide whether prediction is expected.
module tb_fetch_unit;

`ifdef FETCH_BP_EN
  localparam bit BpEn = 1'b1;
`else
  localparam bit BpEn = 1'b0;
`endif
  localparam int PcBits = 5;
  localparam int NumPc  = 32;
  localparam int NumEnt = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall_F;
  logic              EX_taken;
  logic [PcBits-1:0] EX_redirect_pc;
  logic              EX_bp_update;
  logic [PcBits-1:0] EX_bp_pc;
  logic [PcBits-1:0] EX_bp_target;
  logic              EX_bp_outcome;
  logic [PcBits-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [PcBits-1:0] F_pc;
  logic [31:0]       F_inst;
  logic              F_BP_taken;

  logic [31:0] mem [NumPc];
  assign imem_rdata = mem[imem_addr];

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall_F       (stall_F),
    .EX_taken      (EX_taken),
    .EX_redirect_pc(EX_redirect_pc),
    .EX_bp_update  (EX_bp_update),
    .EX_bp_pc      (EX_bp_pc),
    .EX_bp_target  (EX_bp_target),
    .EX_bp_outcome (EX_bp_outcome),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .F_pc          (F_pc),
    .F_inst        (F_inst),
    .F_BP_taken    (F_BP_taken)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integers, one record per BTB slot.
  int m_pc;
  bit m_valid [NumEnt];
  int m_tag   [NumEnt];
  int m_tgt   [NumEnt];
  int m_ctr   [NumEnt];

  function automatic bit m_predicts(int pc);
    int idx = pc % NumEnt;
    return BpEn && m_valid[idx] && (m_tag[idx] == pc / NumEnt) && (m_ctr[idx] >= 2);
  endfunction

  task automatic m_reset();
    m_pc = 0;
    for (int i = 0; i < NumEnt; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endtask

  // One clock: drive, check the current fetch, then advance the model across the edge.
  task automatic step(input bit r, input bit st, input bit ex, input int rpc,
                      input bit up, input int upc, input int utg, input bit uo);
    int nxt;
    int idx;
    rst            = r;
    stall_F        = st;
    EX_taken       = ex;
    EX_redirect_pc = rpc[PcBits-1:0];
    EX_bp_update   = up;
    EX_bp_pc       = upc[PcBits-1:0];
    EX_bp_target   = utg[PcBits-1:0];
    EX_bp_outcome  = uo;
    #3;
    check_eq("f_pc", 32'(F_pc), m_pc);
    check_eq("imem_addr", 32'(imem_addr), m_pc);
    check_eq("f_inst", F_inst, mem[m_pc]);
    check_eq("f_bp_taken", 32'(F_BP_taken), 32'(m_predicts(m_pc) && !ex));
    if (r) begin
      m_reset();
    end else begin
      if (ex) nxt = rpc;
      else if (st) nxt = m_pc;
      else if (m_predicts(m_pc)) nxt = m_tgt[m_pc % NumEnt];
      else nxt = (m_pc + 1) % NumPc;
      if (BpEn && up) begin
        idx = upc % NumEnt;
        if (m_valid[idx] && m_tag[idx] == upc / NumEnt) begin
          if (uo) begin
            m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
            m_tgt[idx] = utg;
          end else begin
            m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
          end
        end else if (uo) begin
          m_valid[idx] = 1'b1;
          m_tag[idx]   = upc / NumEnt;
          m_tgt[idx]   = utg;
          m_ctr[idx]   = 2;
        end
      end
      m_pc = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic redirect(input int pc);
    step(0, 0, 1, pc, 0, 0, 0, 0);
  endtask

  task automatic bp_upd(input int pc, input int tgt, input bit taken);
    step(0, 1, 0, 0, 1, pc, tgt, taken);
  endtask

  initial begin
    for (int i = 0; i < NumPc; i++) mem[i] = 32'(i);
    rst = 1'b1; stall_F = 1'b0; EX_taken = 1'b0; EX_redirect_pc = '0;
    EX_bp_update = 1'b0; EX_bp_pc = '0; EX_bp_target = '0; EX_bp_outcome = 1'b0;
    @(posedge clk);
    #1;
    m_reset();
    // Update during reset must be dropped.
    step(1, 0, 0, 0, 1, 4, 12, 1);

    // Six free-running fetches from reset with imem[i] = i.
    for (int i = 0; i < 6; i++) idle();

    for (int i = 0; i < NumPc; i++) mem[i] = $urandom;

    // PC wraps from all-ones to zero.
    redirect(31);
    idle();
    idle();

    // Allocate then hit at PC 4; two not-taken updates weaken it below threshold.
    bp_upd(4, 12, 1);
    redirect(4);
    idle();
    idle();
    bp_upd(4, 12, 0);
    bp_upd(4, 12, 0);
    redirect(4);
    idle();
    idle();

    // Stall holds PC 7, then a redirect wins over the stall.
    redirect(7);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 20, 0, 0, 0, 0);
    idle();

    // Aliasing: PC 12 shares PC 4's slot with a different tag and then replaces it.
    bp_upd(4, 12, 1);
    redirect(12);
    idle();
    bp_upd(12, 2, 1);
    redirect(4);
    idle();
    redirect(12);
    idle();
    idle();

    // Reset overrides a simultaneous stall and redirect.
    step(1, 1, 1, 20, 1, 5, 9, 1);
    idle();
    idle();

    for (int n = 0; n < 400; n++) begin
      bit r  = ($urandom_range(0, 49) == 0);
      bit st = ($urandom_range(0, 3) == 0);
      bit ex = ($urandom_range(0, 9) == 0);
      bit up = ($urandom_range(0, 2) == 0);
      int upc = $urandom_range(0, 3) * NumEnt + $urandom_range(2, 5);
      step(r, st, ex, $urandom_range(0, NumPc - 1), up, upc,
           $urandom_range(0, NumPc - 1), $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
